// File: rtl/sample_pkg.sv
// Shared types and helpers for the operand issuer.
package sample_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {IDLE, SEND, HOLD, WAIT_T, RESULT, GAP} state_e;

  // Operand layout expected by sample_controller: {pad, c, b, a}.
  function automatic logic [WORD_W-1:0] pack_word(input logic [BYTE_W-1:0] a,
                                                  input logic [BYTE_W-1:0] b,
                                                  input logic [BYTE_W-1:0] c);
    return {{(WORD_W - 3 * BYTE_W){1'b0}}, c, b, a};
  endfunction

endpackage

// File: rtl/operand_issuer_if.sv
// Host push port, sample_controller handshake and result port of the operand issuer.
interface operand_issuer_if;
  import sample_pkg::*;

  logic              push_valid;
  logic              push_ready;
  logic [BYTE_W-1:0] push_a;
  logic [BYTE_W-1:0] push_b;
  logic [BYTE_W-1:0] push_c;
  logic              r_valid;
  logic [WORD_W-1:0] in_data;
  logic              read_done;
  logic              t_valid;
  logic [BYTE_W-1:0] out_data;
  logic              res_valid;
  logic [BYTE_W-1:0] res_data;
  logic              res_ready;
  logic              busy;
  logic              err_timeout;

  // Issuer side.
  modport slave (
    input  push_valid, push_a, push_b, push_c, read_done, t_valid, out_data, res_ready,
    output push_ready, r_valid, in_data, res_valid, res_data, busy, err_timeout
  );

  // Host / controller side.
  modport master (
    output push_valid, push_a, push_b, push_c, read_done, t_valid, out_data, res_ready,
    input  push_ready, r_valid, in_data, res_valid, res_data, busy, err_timeout
  );

endinterface

// File: rtl/operand_fifo.sv
// Synchronous operand FIFO; push_ready is held low while reset is asserted.
module operand_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid_i,
  input  logic [Width-1:0] push_data_i,
  output logic             push_ready_o,
  input  logic             pop_i,
  output logic             not_empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_en;
  logic             pop_en;

  assign push_ready_o = !rst && (count_q != CntW'(Depth));
  assign not_empty_o  = (count_q != '0);
  assign head_o       = mem_q[rd_ptr_q];
  assign push_en      = push_valid_i && push_ready_o;
  assign pop_en       = pop_i && not_empty_o;

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_en && !pop_en)      count_q <= count_q + 1'b1;
      else if (!push_en && pop_en) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/operand_issuer.sv
// Operand issuer: queues operand triples, issues them one at a time to sample_controller
// and returns the MAC result. Optional watchdog enabled by OPERAND_ISSUER_TIMEOUT_EN.
module operand_issuer
  import sample_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_CYCLES = 10,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic               clk,
  input logic               rst,
  operand_issuer_if.slave   bus
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] in_data_q, in_data_d;
  logic              res_valid_q, res_valid_d;
  logic [BYTE_W-1:0] res_data_q, res_data_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic              gap_done;
  logic              pop;
  logic              fifo_not_empty;
  logic [3*BYTE_W-1:0] fifo_head;

  operand_fifo #(
    .Depth (DEPTH),
    .Width (3 * BYTE_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (bus.push_valid),
    .push_data_i  ({bus.push_c, bus.push_b, bus.push_a}),
    .push_ready_o (bus.push_ready),
    .pop_i        (pop),
    .not_empty_o  (fifo_not_empty),
    .head_o       (fifo_head)
  );

  // GAP_CYCLES == 0 still spends the single GAP cycle before returning to IDLE.
  assign gap_done = (GAP_CYCLES == 0) || (gap_cnt_q == GapW'(GAP_CYCLES - 1));

`ifdef OPERAND_ISSUER_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           err_q, err_d;
  logic           to_hit;

  assign to_hit = (to_cnt_q == ToW'(TIMEOUT - 1));
`endif

  // Next-state and datapath decode.
  always_comb begin
    state_d     = state_q;
    in_data_d   = in_data_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    gap_cnt_d   = gap_cnt_q;
    pop         = 1'b0;
`ifdef OPERAND_ISSUER_TIMEOUT_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (fifo_not_empty) begin
          pop       = 1'b1;
          in_data_d = pack_word(fifo_head[BYTE_W-1:0], fifo_head[2*BYTE_W-1:BYTE_W],
                                fifo_head[3*BYTE_W-1:2*BYTE_W]);
          state_d   = SEND;
        end
      end
      SEND: begin
        // A t_valid coinciding with read_done here is dropped.
        if (bus.read_done) begin
          state_d = HOLD;
        end
`ifdef OPERAND_ISSUER_TIMEOUT_EN
        else if (to_hit) begin
          err_d       = 1'b1;
          res_valid_d = 1'b1;
          res_data_d  = 8'hFF;
          state_d     = RESULT;
        end
`endif
      end
      HOLD: begin
        state_d = WAIT_T;
      end
      WAIT_T: begin
        if (bus.t_valid) begin
          res_data_d  = bus.out_data;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end
`ifdef OPERAND_ISSUER_TIMEOUT_EN
        else if (to_hit) begin
          err_d       = 1'b1;
          res_valid_d = 1'b1;
          res_data_d  = 8'hFF;
          state_d     = RESULT;
        end
`endif
      end
      RESULT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          in_data_d   = '0;
          gap_cnt_d   = '0;
          state_d     = GAP;
        end
      end
      GAP: begin
        if (gap_done) state_d = IDLE;
        else          gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
`ifdef OPERAND_ISSUER_TIMEOUT_EN
    // Watchdog restarts whenever a waiting state is entered or left.
    to_cnt_d = ((state_q == SEND || state_q == WAIT_T) && state_d == state_q) ?
               to_cnt_q + 1'b1 : '0;
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_data_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_data_q   <= in_data_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

`ifdef OPERAND_ISSUER_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.r_valid   = (state_q == SEND) || (state_q == HOLD);
  assign bus.in_data   = in_data_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_operand_issuer.sv
// Self-checking bench for operand_issuer: vector table plus hand-written corner sequences,
// with a scoreboard for issued words and returned results.
module tb_operand_issuer;
  import sample_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_issuer_if bus ();

  operand_issuer #(
    .DEPTH      (4),
    .GAP_CYCLES (10),
    .TIMEOUT    (255)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_words[$];
  logic [7:0]  exp_res[$];

  typedef struct {
    logic [7:0]  a, b, c;
    logic [31:0] word;
    int          rd_dly, t_dly, rr_dly;
    bit          early_t;
    logic [7:0]  res;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares each new issue and each new result.
  initial begin
    logic prev_rv, prev_resv, issued;
    logic [31:0] last_word, w;
    logic [7:0] r;
    int gap_run;
    prev_rv = 0; prev_resv = 0; issued = 0; gap_run = 0; last_word = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rv = 0; prev_resv = 0; issued = 0; gap_run = 0;
      end else begin
        if (bus.r_valid && !prev_rv) begin
          if (exp_words.size() == 0) begin
            bound_fail("issue_unexpected");
          end else begin
            w = exp_words.pop_front();
            chk("issue_word", bus.in_data, w);
          end
          if (issued) chk("gap_ge_10", 32'(gap_run >= 10), 32'd1);
          issued = 1;
          last_word = bus.in_data;
        end else if (bus.r_valid) begin
          chk("in_data_stable", bus.in_data, last_word);
        end
        if (bus.res_valid && !prev_resv) begin
          if (exp_res.size() == 0) begin
            bound_fail("result_unexpected");
          end else begin
            r = exp_res.pop_front();
            chk("result_data", 32'(bus.res_data), 32'(r));
          end
        end
        gap_run = (!bus.r_valid && bus.in_data == '0) ? gap_run + 1 : 0;
        prev_rv = bus.r_valid;
        prev_resv = bus.res_valid;
      end
    end
  end

  task automatic drive_triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [31:0] word, input logic [7:0] res);
    exp_words.push_back(word);
    exp_res.push_back(res);
    bus.push_a = a; bus.push_b = b; bus.push_c = c;
    bus.push_valid = 1'b1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [31:0] word, input logic [7:0] res);
    drive_triple(a, b, c, word, res);
    for (int n = 0; n < 200 && !bus.push_ready; n++) tick();
    if (!bus.push_ready) bound_fail("push_wait");
    else tick();
    bus.push_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && bus.busy; n++) tick();
    if (bus.busy) bound_fail("wait_idle");
  endtask

  task automatic wait_rv();
    for (int n = 0; n < 100 && !bus.r_valid; n++) tick();
    if (!bus.r_valid) bound_fail("wait_r_valid");
  endtask

  // Plays sample_controller for one transaction, then the result consumer.
  task automatic serve(input int rd_dly, input int t_dly, input int rr_dly, input bit early_t,
                       input logic [7:0] res);
    wait_rv();
    for (int i = 0; i < rd_dly; i++) begin
      tick();
      chk("send_r_valid", bus.r_valid, 1);
    end
    bus.read_done = 1'b1;
    if (early_t) begin
      bus.t_valid  = 1'b1;
      bus.out_data = 8'hEE;
    end
    tick();
    bus.read_done = 1'b0;
    bus.t_valid   = 1'b0;
    chk("hold_r_valid", bus.r_valid, 1);
    tick();
    chk("r_valid_drop", bus.r_valid, 0);
    chk("wait_busy", bus.busy, 1);
    chk("wait_no_res", bus.res_valid, 0);
    for (int i = 0; i < t_dly; i++) begin
      tick();
      chk("wait_no_res", bus.res_valid, 0);
    end
    bus.t_valid  = 1'b1;
    bus.out_data = res;
    tick();
    bus.t_valid = 1'b0;
    chk("res_valid", bus.res_valid, 1);
    chk("res_data", 32'(bus.res_data), 32'(res));
    for (int i = 0; i < rr_dly; i++) begin
      tick();
      chk("res_hold", {bus.res_valid, bus.res_data, bus.r_valid}, {1'b1, res, 1'b0});
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("res_cleared", bus.res_valid, 0);
    chk("gap_busy", bus.busy, 1);
  endtask

  initial begin
    vecs[0] = '{8'b10000101, 8'b00010100, 8'd9, 32'h00091485, 2, 1, 2, 1'b0, 8'h07};
    vecs[1] = '{8'hFF, 8'h00, 8'hAA, 32'h00AA00FF, 0, 0, 0, 1'b1, 8'h55};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 32'h00000000, 5, 4, 0, 1'b0, 8'h00};
    vecs[3] = '{8'h3C, 8'h5A, 8'hC3, 32'h00C35A3C, 1, 0, 3, 1'b1, 8'h81};

    bus.push_valid = 0; bus.push_a = 0; bus.push_b = 0; bus.push_c = 0;
    bus.read_done = 0; bus.t_valid = 0; bus.out_data = 0; bus.res_ready = 0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_outputs", {bus.r_valid, bus.res_valid, bus.busy, bus.err_timeout, bus.push_ready},
        5'b0);
    chk("rst_in_data", bus.in_data, 32'h0);
    rst = 1'b0;
    tick();
    chk("push_ready_after_rst", bus.push_ready, 1);

    // Table: one transaction per vector from IDLE, with 1-cycle issue latency.
    for (int i = 0; i < 4; i++) begin
      wait_idle();
      push(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].word, vecs[i].res);
      chk("issue_lat_pre", bus.r_valid, 0);
      tick();
      chk("issue_lat", bus.r_valid, 1);
      serve(vecs[i].rd_dly, vecs[i].t_dly, vecs[i].rr_dly, vecs[i].early_t, vecs[i].res);
    end

    // Back-to-back: second word waits in the FIFO while the result is stalled 20 cycles.
    wait_idle();
    push(8'h07, 8'h40, 8'h03, 32'h00034007, 8'h0A);
    push(8'h89, 8'hC1, 8'h83, 32'h0083C189, 8'h06);
    serve(0, 0, 20, 1'b0, 8'h0A);
    serve(1, 2, 0, 1'b0, 8'h06);

    // Fill: first triple pops straight into SEND, four more fill the FIFO.
    wait_idle();
    push(8'h01, 8'h11, 8'h21, 32'h00211101, 8'hA1);
    push(8'h02, 8'h12, 8'h22, 32'h00221202, 8'hA2);
    push(8'h03, 8'h13, 8'h23, 32'h00231303, 8'hA3);
    push(8'h04, 8'h14, 8'h24, 32'h00241404, 8'hA4);
    push(8'h05, 8'h15, 8'h25, 32'h00251505, 8'hA5);
    chk("fifo_full", bus.push_ready, 0);
    drive_triple(8'h06, 8'h16, 8'h26, 32'h00261606, 8'hA6);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_stall", bus.push_ready, 0);
    end
    serve(0, 0, 0, 1'b0, 8'hA1);
    for (int n = 0; n < 50 && !bus.push_ready; n++) tick();
    if (!bus.push_ready) bound_fail("push_after_pop");
    else tick();
    bus.push_valid = 1'b0;
    serve(0, 0, 0, 1'b0, 8'hA2);
    serve(1, 0, 0, 1'b0, 8'hA3);
    serve(0, 1, 0, 1'b0, 8'hA4);
    serve(0, 0, 1, 1'b0, 8'hA5);
    serve(0, 0, 0, 1'b0, 8'hA6);
    wait_idle();
    chk("queues_drained", 32'(exp_words.size() + exp_res.size()), 32'd0);

    // Reset in WAIT_T with a second triple still queued.
    push(8'h11, 8'h22, 8'h33, 32'h00332211, 8'h44);
    push(8'h55, 8'h66, 8'h77, 32'h00776655, 8'h88);
    wait_rv();
    bus.read_done = 1'b1;
    tick();
    bus.read_done = 1'b0;
    tick();
    chk("pre_rst_wait_t", {bus.r_valid, bus.busy}, 2'b01);
    rst = 1'b1;
    tick();
    chk("rst_abort", {bus.r_valid, bus.res_valid, bus.busy}, 3'b000);
    rst = 1'b0;
    exp_words.delete();
    exp_res.delete();
    bus.t_valid = 1'b1;
    bus.out_data = 8'h99;
    tick();
    bus.t_valid = 1'b0;
    chk("push_ready_post_rst", bus.push_ready, 1);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("post_rst_idle", {bus.r_valid, bus.res_valid, bus.busy}, 3'b000);
    end

`ifdef OPERAND_ISSUER_TIMEOUT_EN
    begin
      int n;
      push(8'h01, 8'h02, 8'h03, 32'h00030201, 8'hFF);
      wait_rv();
      n = 0;
      while (bus.r_valid && n < 400) begin
        n++;
        tick();
      end
      chk("timeout_cycles", 32'(n), 32'd255);
      chk("timeout_flags", {bus.err_timeout, bus.res_valid, bus.r_valid}, 3'b110);
      chk("timeout_data", 32'(bus.res_data), 32'hFF);
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      chk("err_sticky", bus.err_timeout, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("err_cleared", bus.err_timeout, 0);
    end
`else
    push(8'h01, 8'h02, 8'h03, 32'h00030201, 8'h5A);
    wait_rv();
    repeat (1000) tick();
    chk("no_timeout_r_valid", bus.r_valid, 1);
    chk("no_timeout_err", bus.err_timeout, 0);
    serve(0, 0, 0, 1'b0, 8'h5A);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
